// File: rtl/cr_fifo_pkg.sv
// Shared definitions for the cr_fifo family: width helpers, mode encodings and
// the depth legality check used by every FIFO variant.

`ifndef CR_FIFO_POW2_CHECK
// Elaboration-time guard: depth must be a power of two and at least 2.
`define CR_FIFO_POW2_CHECK(depth) \
  if (((depth) < 2) || (((depth) & ((depth) - 1)) != 0)) begin : gDepthNotPow2 \
    $error("cr_fifo: pDepth must be a power of two and >= 2"); \
  end
`endif

package cr_fifo_pkg;

  // Error reporting modes
  localparam int unsigned ERR_STICKY = 0;
  localparam int unsigned ERR_PULSE  = 1;

  // Read path modes
  localparam int unsigned READ_REG  = 0;
  localparam int unsigned READ_FWFT = 1;

  // Pointer width for a given depth
  function automatic int unsigned crAddrWidth(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Count width: one extra bit so the count can represent a full FIFO
  function automatic int unsigned crCountWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cr_fifoctl_s1_df.sv
// FIFO control: pointers, word count, accept decisions, status flags and
// overflow/underflow reporting. Storage lives in the parent.

module cr_fifoctl_s1_df
  import cr_fifo_pkg::*;
#(
  parameter int unsigned pDepth   = 16,
  parameter int unsigned pErrMode = ERR_STICKY,
  localparam int unsigned AW      = crAddrWidth(pDepth),
  localparam int unsigned CW      = crCountWidth(pDepth)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          PushReq_n,
  input  logic          PopReq_n,
  input  logic [CW-1:0] AeLevel,
  input  logic [CW-1:0] AfLevel,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic          RdEn,
  output logic [AW-1:0] RdAddr,
  output logic [CW-1:0] WordCount,
  output logic          Empty,
  output logic          AlmostEmpty,
  output logic          HalfFull,
  output logic          AlmostFull,
  output logic          Full,
  output logic          PushError,
  output logic          PopError
);

  logic [AW-1:0] wrPtrQ, wrPtrD;
  logic [AW-1:0] rdPtrQ, rdPtrD;
  logic [CW-1:0] countQ, countD;
  logic          pushErrQ, pushErrD;
  logic          popErrQ, popErrD;
  logic          pushBad, popBad;

  // Flags decode the registered count against live thresholds
  always_comb begin
    Empty       = (countQ == '0);
    Full        = (countQ == CW'(pDepth));
    HalfFull    = (countQ >= CW'(pDepth / 2));
    AlmostEmpty = (countQ <= AeLevel);
    AlmostFull  = (countQ >= AfLevel);
  end

  // A request against Full/Empty is rejected outright, even if the opposite
  // side is accepted in the same cycle.
  assign WrEn    = !PushReq_n && !Full;
  assign RdEn    = !PopReq_n && !Empty;
  assign pushBad = !PushReq_n && Full;
  assign popBad  = !PopReq_n && Empty;

  // Next-state for pointers, count and error flags
  always_comb begin
    wrPtrD   = wrPtrQ;
    rdPtrD   = rdPtrQ;
    countD   = countQ;
    pushErrD = pushErrQ;
    popErrD  = popErrQ;
    if (WrEn) wrPtrD = wrPtrQ + AW'(1);
    if (RdEn) rdPtrD = rdPtrQ + AW'(1);
    if (WrEn && !RdEn) begin
      countD = countQ + CW'(1);
    end else if (RdEn && !WrEn) begin
      countD = countQ - CW'(1);
    end
    if (pErrMode == ERR_PULSE) begin
      pushErrD = pushBad;
      popErrD  = popBad;
    end else begin
      pushErrD = pushErrQ | pushBad;
      popErrD  = popErrQ | popBad;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      countQ   <= '0;
      pushErrQ <= 1'b0;
      popErrQ  <= 1'b0;
    end else begin
      wrPtrQ   <= wrPtrD;
      rdPtrQ   <= rdPtrD;
      countQ   <= countD;
      pushErrQ <= pushErrD;
      popErrQ  <= popErrD;
    end
  end

  assign WrAddr    = wrPtrQ;
  assign RdAddr    = rdPtrQ;
  assign WordCount = countQ;
  assign PushError = pushErrQ;
  assign PopError  = popErrQ;

endmodule

// File: rtl/cr_fifo_s1_df.sv
// Single-clock FIFO with run-time thresholds: register-array storage plus the
// read data path (registered or first-word-fall-through).

module cr_fifo_s1_df
  import cr_fifo_pkg::*;
#(
  parameter int unsigned pWidth       = 8,
  parameter int unsigned pDepth       = 16,
  parameter int unsigned pFallThrough = READ_REG,
  parameter int unsigned pErrMode     = ERR_STICKY,
  localparam int unsigned CW          = crCountWidth(pDepth)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PushReq_n,
  input  logic [pWidth-1:0] PushData,
  input  logic              PopReq_n,
  output logic [pWidth-1:0] PopData,
  input  logic [CW-1:0]     AeLevel,
  input  logic [CW-1:0]     AfLevel,
  output logic [CW-1:0]     WordCount,
  output logic              Empty,
  output logic              AlmostEmpty,
  output logic              HalfFull,
  output logic              AlmostFull,
  output logic              Full,
  output logic              PushError,
  output logic              PopError
);

  localparam int unsigned AW = crAddrWidth(pDepth);

  `CR_FIFO_POW2_CHECK(pDepth)

  logic              wrEn, rdEn;
  logic [AW-1:0]     wrAddr, rdAddr;
  logic [pWidth-1:0] mem [pDepth];

  cr_fifoctl_s1_df #(
    .pDepth   (pDepth),
    .pErrMode (pErrMode)
  ) uCtl (
    .Clk         (Clk),
    .Rst         (Rst),
    .PushReq_n   (PushReq_n),
    .PopReq_n    (PopReq_n),
    .AeLevel     (AeLevel),
    .AfLevel     (AfLevel),
    .WrEn        (wrEn),
    .WrAddr      (wrAddr),
    .RdEn        (rdEn),
    .RdAddr      (rdAddr),
    .WordCount   (WordCount),
    .Empty       (Empty),
    .AlmostEmpty (AlmostEmpty),
    .HalfFull    (HalfFull),
    .AlmostFull  (AlmostFull),
    .Full        (Full),
    .PushError   (PushError),
    .PopError    (PopError)
  );

  // Storage write; contents are deliberately not reset
  always_ff @(posedge Clk) begin
    if (wrEn) mem[wrAddr] <= PushData;
  end

  if (pFallThrough == READ_FWFT) begin : gFwft
    // Head word shown directly; meaningless while Empty
    assign PopData = mem[rdAddr];
  end else begin : gReg
    logic [pWidth-1:0] popDataQ;

    // Capture the head word on each accepted pop
    always_ff @(posedge Clk) begin
      if (Rst) begin
        popDataQ <= '0;
      end else if (rdEn) begin
        popDataQ <= mem[rdAddr];
      end
    end

    assign PopData = popDataQ;
  end

endmodule
